// File: rtl/sparc_rr4_selgen_if.sv
// Request/select bundle between a round-robin select generator and its requesters.
// The master side drives requests and stall; the slave side returns the registered selects.
interface sparc_rr4_selgen_if;
  logic [3:0] req;
  logic       stall;
  logic [3:0] sel_l;
  logic [1:0] sel_enc;
  logic       vld;
  logic       sw;

  modport master (
    output req, stall,
    input  sel_l, sel_enc, vld, sw
  );

  modport slave (
    input  req, stall,
    output sel_l, sel_enc, vld, sw
  );
endinterface

// File: rtl/sparc_rr4_selgen.sv
// Registered 4-way round-robin select generator: one-cold active-low decoded select
// plus the matching encoded index, with a minimum hold time per grant.
module sparc_rr4_selgen #(
  parameter int unsigned HOLD = 1
) (
  input  logic                rclk,
  input  logic                reset,
  sparc_rr4_selgen_if.slave   bus
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  logic [1:0] cur, cur_n;
  logic       vld_r, vld_n;
  logic [3:0] cnt, cnt_n;
  logic       sw_r, sw_n;

  logic [1:0] start;
  logic [1:0] winner;
  logic       keep;

  // cnt stops at HOLD_LAST, so inequality is the same as "below HOLD_LAST";
  // with HOLD=1 it is always equal and keep never fires.
  assign keep  = vld_r && bus.req[cur] && (cnt != HOLD_LAST);
  assign start = vld_r ? cur + 2'd1 : cur;

  // NOTE: every signal written in a combinational block gets a default first,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    winner = start;
    // Walk from the farthest offset back to start so the nearest asserted bit wins.
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[start + 2'(k)]) winner = start + 2'(k);
    end
  end

  always_comb begin
    cur_n = cur;
    vld_n = vld_r;
    cnt_n = cnt;
    sw_n  = 1'b0;
    if (bus.stall) begin
      // All state frozen; only the switch pulse is suppressed.
    end else if (keep) begin
      cnt_n = cnt + 4'd1;
      vld_n = 1'b1;
    end else if (|bus.req) begin
      cur_n = winner;
      vld_n = 1'b1;
      cnt_n = 4'd0;
      sw_n  = (winner != cur);
    end else begin
      vld_n = 1'b0;
      cnt_n = 4'd0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge rclk) begin
    if (reset) begin
      cur   <= 2'd0;
      vld_r <= 1'b0;
      cnt   <= 4'd0;
      sw_r  <= 1'b0;
    end else begin
      cur   <= cur_n;
      vld_r <= vld_n;
      cnt   <= cnt_n;
      sw_r  <= sw_n;
    end
  end

  // Selects decode straight from the index register, so they stay one-cold.
  assign bus.sel_l   = ~(4'b0001 << cur);
  assign bus.sel_enc = cur;
  assign bus.vld     = vld_r;
  assign bus.sw      = sw_r;

endmodule
